// File: rtl/execute.sv
// Execute stage: one-entry valid/ready pipeline register holding the ALU result,
// with branch/jump resolution and wrong-path squashing after a taken redirect.
module execute #(
  parameter int unsigned SQUASH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] I,
  input  logic [31:0] PC,
  input  logic        v_in,
  input  logic        r_in,
  output logic        r_out,
  output logic        v_out,
  output logic [31:0] IR_out,
  output logic [31:0] R_out,
  output logic [31:0] B_out,
  output logic [31:0] PC_out,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic             full;
  logic [CNT_W-1:0] squash_cnt;
  logic             accept;
  logic             retire;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  op2;
  logic [4:0]       shamt;
  logic [XLEN-1:0]  sum_ai;
  logic [XLEN-1:0]  result;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             slt_s;
  logic             slt_u;
  logic             br_eq;
  logic             br_lt_s;
  logic             br_lt_u;
  logic             unused_ir;

  assign r_out  = !full | r_in;
  assign v_out  = full;
  assign accept = v_in & r_out;
  assign retire = full & r_in;

  assign opcode    = IR[6:0];
  assign funct3    = IR[14:12];
  assign unused_ir = ^{IR[31], IR[29:15], IR[11:7]};

  assign op2     = (opcode == OPC_OP) ? B : I;
  assign shamt   = op2[4:0];
  assign sum_ai  = A + I;
  assign slt_s   = $signed(A) < $signed(op2);
  assign slt_u   = A < op2;
  assign br_eq   = A == B;
  assign br_lt_s = $signed(A) < $signed(B);
  assign br_lt_u = A < B;

  // Result, taken flag and redirect target for the instruction on the inputs
  always_comb begin
    result = '0;
    taken  = 1'b0;
    target = '0;
    unique case (opcode)
      OPC_LUI:   result = I;
      OPC_AUIPC: result = PC + I;
      OPC_JAL: begin
        result = PC + XLEN'(4);
        taken  = 1'b1;
        target = PC + I;
      end
      OPC_JALR: begin
        result = PC + XLEN'(4);
        taken  = 1'b1;
        target = {sum_ai[XLEN-1:1], 1'b0};
      end
      OPC_LOAD, OPC_STORE: result = sum_ai;
      OPC_BRANCH: begin
        target = PC + I;
        unique case (funct3)
          3'b000:  taken = br_eq;
          3'b001:  taken = !br_eq;
          3'b100:  taken = br_lt_s;
          3'b101:  taken = !br_lt_s;
          3'b110:  taken = br_lt_u;
          3'b111:  taken = !br_lt_u;
          default: taken = 1'b0;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        unique case (funct3)
          3'b000:  result = (opcode == OPC_OP && IR[30]) ? (A - op2) : (A + op2);
          3'b001:  result = A << shamt;
          3'b010:  result = XLEN'(slt_s);
          3'b011:  result = XLEN'(slt_u);
          3'b100:  result = A ^ op2;
          3'b101:  result = IR[30] ? XLEN'($signed(A) >>> shamt) : (A >> shamt);
          3'b110:  result = A | op2;
          default: result = A & op2;
        endcase
      end
      default: begin
        result = '0;
        taken  = 1'b0;
      end
    endcase
  end

  // Pipeline register; squashed accepts consume an input slot but never fill the entry
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      squash_cnt  <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      IR_out      <= '0;
      R_out       <= '0;
      B_out       <= '0;
      PC_out      <= '0;
    end else begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
      if (accept) begin
        if (squash_cnt != '0) begin
          squash_cnt <= squash_cnt - CNT_W'(1);
          if (retire) full <= 1'b0;
        end else begin
          full   <= 1'b1;
          IR_out <= IR;
          PC_out <= PC;
          B_out  <= B;
          R_out  <= result;
          if (taken) begin
            redirect    <= 1'b1;
            redirect_pc <= target;
            squash_cnt  <= CNT_W'(SQUASH_DEPTH);
          end
        end
      end else if (retire) begin
        full <= 1'b0;
      end
    end
  end

endmodule
